// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial WIDTH-bit full adder with a start/busy/done handshake.
// One full-adder cell processes one bit pair per cycle, LSB first, using a registered carry.
// The result and carry-out are registered and held until the next done pulse.
// Optional feature: define SERIAL_ADDER_FSM_OVF_EN to add the signed-overflow output 'ovf'.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_FSM_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c;
    logic [CNT_W-1:0] count;

    logic             bit_s;
    logic             carry_next;
    logic             last;

    // Single full-adder cell operating on the current LSBs and the registered carry.
    assign bit_s      = a_sh[0] ^ b_sh[0] ^ c;
    assign carry_next = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    assign last       = (count == CNT_W'(WIDTH - 1));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit, DONE -> IDLE.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: operand capture, bit-serial shifting, and result load on the final RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_FSM_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        count <= '0;
                        s_sh  <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh  <= {bit_s, s_sh[WIDTH-1:1]};
                    c     <= carry_next;
                    count <= count + 1'b1;
                    // The visible result is replaced only as a whole, never bit by bit.
                    if (last) begin
                        sum  <= {bit_s, s_sh[WIDTH-1:1]};
                        cout <= carry_next;
`ifdef SERIAL_ADDER_FSM_OVF_EN
                        // Carry into the MSB is c on this cycle; carry out of the MSB is carry_next.
                        ovf  <= c ^ carry_next;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: directed and random self-checking bench for serial_adder_fsm (WIDTH=8).
// Build with SERIAL_ADDER_FSM_OVF_EN defined to also check the ovf output.
module tb_serial_adder_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_FSM_OVF_EN
    logic         ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_FSM_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
        logic [W:0] r;
        r = model_sum(x, y, ci);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Launch one operation from IDLE and follow it until busy drops (bounded).
    // lat = samples after the accepting edge until done; bcnt = samples with busy high.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         output int lat, output int bcnt, output int dcnt);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        lat = -1; bcnt = 0; dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) lat = i;
            end
            if (!busy) break;
            tick();
        end
    endtask

    // One arithmetic vector: latency, busy length, single done pulse and result.
    task automatic test_vector(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic ic);
        int lat, bcnt, dcnt;
        logic [W:0] exp;
        exp = model_sum(ia, ib, ic);
        do_op(ia, ib, ic, lat, bcnt, dcnt);
        vectors++;
        if (lat !== W) begin
            miscompares++;
            $display("FAIL %s latency: got %0d samples, expected %0d", name, lat, W);
        end
        vectors++;
        if (bcnt !== W + 1) begin
            miscompares++;
            $display("FAIL %s busy_len: got %0d, expected %0d", name, bcnt, W + 1);
        end
        vectors++;
        if (dcnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, expected 1", name, dcnt);
        end
        vectors++;
        if ({cout, sum} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got cout=%b sum=%h, expected cout=%b sum=%h",
                     name, cout, sum, exp[W], exp[W-1:0]);
        end
`ifdef SERIAL_ADDER_FSM_OVF_EN
        vectors++;
        if (ovf !== model_ovf(ia, ib, ic)) begin
            miscompares++;
            $display("FAIL %s ovf: got %b, expected %b", name, ovf, model_ovf(ia, ib, ic));
        end
`endif
    endtask

    // Reset with start asserted: reset wins and all outputs are zero.
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, expected all 0",
                     busy, done, cout, sum);
        end
`ifdef SERIAL_ADDER_FSM_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b, expected 0", ovf);
        end
`endif
        rst = 1'b0; start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_basic();
        // 0x3C + 0x5A = 0x96: done visible on the 9th edge counting the accepting edge.
        test_vector("basic_3c_5a", 8'h3C, 8'h5A, 1'b0);
    endtask

    task automatic test_carry();
        test_vector("carry_ff_01", 8'hFF, 8'h01, 1'b0);
        test_vector("carry_80_80", 8'h80, 8'h80, 1'b0);
        test_vector("cin_00_00", 8'h00, 8'h00, 1'b1);
        test_vector("cin_ff_ff", 8'hFF, 8'hFF, 1'b1);
        test_vector("ovf_7f_00_c", 8'h7F, 8'h00, 1'b1);
    endtask

    // start held high with operands changing every cycle.
    task automatic test_back_to_back();
        logic [W:0]   q[$];
        logic [W-1:0] last_sum;
        logic         last_cout;
        int           last_done;
        int           ndone;
        last_sum = sum; last_cout = cout; last_done = -1; ndone = 0;
        start = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
            if (!busy) q.push_back(model_sum(a, b, cin));
            tick();
            if (done) begin
                ndone++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_result: got done with no accepted operands, expected none");
                end else begin
                    if ({cout, sum} !== q[0]) begin
                        miscompares++;
                        $display("FAIL b2b_result: got %h, expected %h", {cout, sum}, q[0]);
                    end
                    q.pop_front();
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (cyc - last_done !== 10) begin
                        miscompares++;
                        $display("FAIL b2b_period: got %0d cycles, expected 10", cyc - last_done);
                    end
                end
                last_done = cyc; last_sum = sum; last_cout = cout;
            end else begin
                vectors++;
                if ({cout, sum} !== {last_cout, last_sum}) begin
                    miscompares++;
                    $display("FAIL b2b_stable: got %h, expected %h", {cout, sum},
                             {last_cout, last_sum});
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (ndone !== 6) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d dones, expected 6", ndone);
        end
        for (int i = 0; i < 20 && busy; i++) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got busy=%b, expected 0", busy);
        end
    endtask

    // Reset in the third RUN cycle aborts the operation without a done pulse.
    task automatic test_mid_reset();
        int seen_done;
        test_vector("pre_rst_11_22", 8'h11, 8'h22, 1'b0);
        a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_running: got busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("FAIL midrst_outputs: got busy=%b done=%b cout=%b sum=%h, expected all 0",
                     busy, done, cout, sum);
        end
`ifdef SERIAL_ADDER_FSM_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_ovf: got %b, expected 0", ovf);
        end
`endif
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got %0d active cycles, expected 0", seen_done);
        end
        test_vector("post_rst_a5_5a", 8'hA5, 8'h5A, 1'b1);
    endtask

    task automatic test_random();
        int lat, bcnt, dcnt;
        int bad_sum, bad_busy;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp;
        bad_sum = 0; bad_busy = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
            exp = model_sum(ra, rb, rc);
            do_op(ra, rb, rc, lat, bcnt, dcnt);
            vectors++;
            if ({cout, sum} !== exp) begin
                miscompares++;
                if (bad_sum++ < 5)
                    $display("FAIL rand_result: %h+%h+%b got %h, expected %h",
                             ra, rb, rc, {cout, sum}, exp);
            end
            vectors++;
            if (bcnt !== W + 1) begin
                miscompares++;
                if (bad_busy++ < 5)
                    $display("FAIL rand_busy: got %0d, expected %0d", bcnt, W + 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
